// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals of the memory port arbiter.
// slave modport: arbiter view (requests/memory results in, grants/valids/command out).
// master modport: requester/memory view, the mirror image of slave.
interface mem_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  // instruction-fetch port
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_valid;
  logic [DW-1:0] if_rdata;
  // data port
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_valid;
  logic [DW-1:0] d_rdata;
  // single-port memory
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  // sticky timeout flag
  logic          err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: arbitrates an instruction-fetch port and a data port onto one single-port memory.
// Latency: req at N -> gnt N+1 -> earliest mem_ready N+2 -> valid N+3; next grant earliest N+5.
// Backpressure: one transaction in flight; requests are sampled only in IDLE and simply wait otherwise.
// Ports: clk, rst (async, active-high); bus (mem_port_arbiter_if.slave) carries
//   fetch req/addr/gnt/valid/rdata, data req/we/addr/wdata/gnt/valid/rdata,
//   memory en/we/addr/wdata/rdata/ready and the sticky err flag.
// Option: define MEM_ARB_RR_EN for round-robin on simultaneous requests
//   (default build: data has fixed priority over fetch).
module mem_port_arbiter #(
  parameter int AW  = 16,
  parameter int DW  = 16,
  parameter int TMO = 16   // WAIT-state timeout in cycles, 2..255
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e        state_q, state_d;

  logic          take;       // a request is being accepted this cycle
  logic          sel_d;      // arbitration winner is the data port
  logic          cnt_done;   // last permitted WAIT cycle
  logic          tmo_hit;    // leaving WAIT without mem_ready

  logic          own_d_q, own_d_d;
  logic [7:0]    cnt_q, cnt_d;

  logic          if_gnt_q, if_gnt_d;
  logic          d_gnt_q, d_gnt_d;
  logic          if_valid_q, if_valid_d;
  logic          d_valid_q, d_valid_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          err_q, err_d;

  assign take     = (state_q == IDLE) && (bus.if_req || bus.d_req);
  assign cnt_done = (cnt_q == 8'(TMO - 1));
  assign tmo_hit  = (state_q == WAIT) && !bus.mem_ready && cnt_done;

`ifdef MEM_ARB_RR_EN
  // pref_d_q=1 means the data port wins the next tie; it flips to whoever
  // lost at every grant, and reset leaves it favouring data.
  logic pref_d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pref_d_q <= 1'b1;
    end else if (take) begin
      pref_d_q <= !sel_d;
    end
  end

  assign sel_d = bus.d_req && (!bus.if_req || pref_d_q);
`else
  assign sel_d = bus.d_req;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.if_req || bus.d_req) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT:  if (bus.mem_ready || cnt_done) state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: every output is computed from the next state so that the
  // flop holding it shows the value in the same cycle the FSM is in that state.
  always_comb begin
    own_d_d     = own_d_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    err_d       = err_q | tmo_hit;
    cnt_d       = (state_q == WAIT) ? 8'(cnt_q + 8'd1) : 8'd0;

    // Command is latched once at acceptance and held until the next grant,
    // which keeps it stable across ISSUE and WAIT.
    if (take) begin
      own_d_d     = sel_d;
      mem_addr_d  = sel_d ? bus.d_addr : bus.if_addr;
      mem_wdata_d = sel_d ? bus.d_wdata : mem_wdata_q;
      mem_we_d    = sel_d && bus.d_we;
    end

    // Read data only lands in the owner's register; writes leave d_rdata alone.
    if ((state_q == WAIT) && bus.mem_ready) begin
      if (own_d_q) begin
        if (!mem_we_q) d_rdata_d = bus.mem_rdata;
      end else begin
        if_rdata_d = bus.mem_rdata;
      end
    end

    mem_en_d   = (state_d == ISSUE);
    if_gnt_d   = (state_d == ISSUE) && !own_d_d;
    d_gnt_d    = (state_d == ISSUE) &&  own_d_d;
    if_valid_d = (state_d == RESP)  && !own_d_q;
    d_valid_d  = (state_d == RESP)  &&  own_d_q;
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own_d_q     <= 1'b0;
      cnt_q       <= 8'd0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      own_d_q     <= own_d_d;
      cnt_q       <= cnt_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      err_q       <= err_d;
    end
  end

  assign bus.if_gnt    = if_gnt_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cases plus randomized
// transactions, each predicted by a transaction-level model (owner, grant
// cycle, valid cycle, held read data, sticky err).
module tb_mem_port_arbiter;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // model state
  logic [DW-1:0] m_if_rdata, m_d_rdata;
  logic          m_err;
  logic          m_pref_d;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m_if_rdata = '0;
    m_d_rdata  = '0;
    m_err      = 1'b0;
    m_pref_d   = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_bits"}, 32'({bus.if_gnt, bus.if_valid, bus.d_gnt, bus.d_valid,
                             bus.mem_en, bus.mem_we, bus.err}), 32'd0);
    chk({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
    chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    chk({tag, "_if_rdata"},  32'(bus.if_rdata),  32'd0);
    chk({tag, "_d_rdata"},   32'(bus.d_rdata),   32'd0);
  endtask

  // One transaction starting in an IDLE cycle. dly = cycles after ISSUE at
  // which memory answers (dly > TMO means it never answers in time).
  task automatic txn(input bit f_en, input bit d_en, input bit we,
                     input logic [AW-1:0] faddr, input logic [AW-1:0] daddr,
                     input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                     input int dly, input bit hold, input bit spurious);
    bit exp_d, got_g, got_v, tmo;
    int gcyc, exp_v;
    logic [AW-1:0] exp_addr;

`ifdef MEM_ARB_RR_EN
    exp_d = (f_en && d_en) ? m_pref_d : d_en;
`else
    exp_d = d_en;
`endif
    tmo      = (dly > TMO);
    exp_v    = tmo ? (TMO + 2) : (dly + 2);
    exp_addr = exp_d ? daddr : faddr;

    @(negedge clk);
    bus.if_req  = f_en;
    bus.if_addr = faddr;
    bus.d_req   = d_en;
    bus.d_we    = we;
    bus.d_addr  = daddr;
    bus.d_wdata = wdata;
    got_g = 0;
    got_v = 0;
    gcyc  = 0;

    for (int cyc = 1; cyc <= TMO + 10 && !got_v; cyc++) begin
      @(negedge clk);
      chk("gnt_excl",   32'(bus.if_gnt & bus.d_gnt), 32'd0);
      chk("valid_excl", 32'(bus.if_valid & bus.d_valid), 32'd0);
      if ((bus.if_gnt || bus.d_gnt) && !got_g) begin
        got_g = 1;
        gcyc  = cyc;
        chk("gnt_cycle", 32'(cyc), 32'd1);
        chk("gnt_owner", 32'(bus.d_gnt), 32'(exp_d));
        chk("mem_en",    32'(bus.mem_en), 32'd1);
        chk("mem_we",    32'(bus.mem_we), 32'(exp_d && we));
        chk("mem_addr",  32'(bus.mem_addr), 32'(exp_addr));
        if (exp_d && we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(wdata));
        m_pref_d = !exp_d;
        if (!hold) begin
          bus.if_req = 1'b0;
          bus.d_req  = 1'b0;
        end
      end else begin
        chk("mem_en_off", 32'(bus.mem_en), 32'd0);
        if (got_g && cyc < exp_v) begin
          chk("addr_hold", 32'(bus.mem_addr), 32'(exp_addr));
          chk("we_hold",   32'(bus.mem_we),   32'(exp_d && we));
        end
      end
      if (bus.if_valid || bus.d_valid) begin
        got_v = 1;
        if (tmo)               m_err = 1'b1;
        else if (!exp_d)       m_if_rdata = rdata;
        else if (!we)          m_d_rdata  = rdata;
        chk("valid_cycle", 32'(cyc), 32'(exp_v));
        chk("valid_owner", 32'(bus.d_valid), 32'(exp_d));
        chk("if_rdata",    32'(bus.if_rdata), 32'(m_if_rdata));
        chk("d_rdata",     32'(bus.d_rdata),  32'(m_d_rdata));
        chk("err",         32'(bus.err),      32'(m_err));
      end
      bus.mem_ready = got_g && !got_v && ((cyc == gcyc + dly) || (spurious && cyc == gcyc));
      bus.mem_rdata = bus.mem_ready ? rdata : DW'($urandom);
    end
    bus.mem_ready = 1'b0;
    if (!got_v) chk("valid_seen", 32'd0, 32'd1);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_zero(tag);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.mem_rdata = '0; bus.mem_ready = 0;
    rst = 1'b1;
    model_reset();
    do_reset("por");

    // contention: both requests held for three back-to-back rounds
    for (int r = 0; r < 3; r++)
      txn(1, 1, 0, 16'h0200 + 16'(r), 16'h0300 + 16'(r), 16'h0, 16'hA000 + 16'(r), 1, 1, 0);
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;

    do_reset("rst2");

    // solo fetch, then data write, then data read at the timeout boundary
    txn(1, 0, 0, 16'h0040, 16'h0, 16'h0, 16'h1234, 1, 0, 0);
    txn(0, 1, 1, 16'h0, 16'h0100, 16'hBEEF, 16'h5555, 1, 0, 0);
    txn(0, 1, 0, 16'h0, 16'h0104, 16'h0, 16'h7A7A, TMO, 0, 1);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      int kind, dly;
      kind = $urandom_range(0, 2);
      dly  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TMO + 2) : $urandom_range(1, 3);
      txn(kind != 1, kind != 0, 1'($urandom), AW'($urandom), AW'($urandom),
          DW'($urandom), DW'($urandom), dly, 0, 1'($urandom));
    end

    // forced timeout, then a normal transaction keeps err set
    txn(1, 0, 0, 16'h0060, 16'h0, 16'h0, 16'hCAFE, TMO + 5, 0, 0);
    txn(1, 0, 0, 16'h0064, 16'h0, 16'h0, 16'h0BAD, 2, 0, 0);

    // reset while in WAIT
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0ABC;
    @(negedge clk);
    chk("rw_gnt", 32'(bus.d_gnt), 32'd1);
    bus.d_req = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check_zero("rst_wait");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 16'hDEAD;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_valid_after_rst", 32'({bus.if_valid, bus.d_valid}), 32'd0);
      bus.mem_ready = 1'b0;
    end
    txn(0, 1, 0, 16'h0, 16'h0AC0, 16'h0, 16'h3C3C, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter AW, default 16, address width.
REQ-002 SHALL have parameter DW, default 16, data width.
REQ-003 SHALL have parameter TMO, default 16, WAIT-state timeout in cycles (2..255).
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports if_req/if_addr  input  1/AW  instruction-fetch read request and address.
REQ-007 SHALL have ports if_gnt/if_valid/if_rdata  output  1/1/DW  fetch grant pulse, completion pulse, read data.
REQ-008 SHALL have ports d_req/d_we/d_addr/d_wdata  input  1/1/AW/DW  data request, write enable, address, write data.
REQ-009 SHALL have ports d_gnt/d_valid/d_rdata  output  1/1/DW  data grant pulse, completion pulse, read data.
REQ-010 SHALL have ports mem_en/mem_we/mem_addr/mem_wdata  output  1/1/AW/DW  single-port memory command.
REQ-011 SHALL have ports mem_rdata/mem_ready  input  DW/1  memory read data and completion strobe.
REQ-012 SHALL have port err  output  1  sticky timeout flag.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; all outputs registered.
REQ-014 SHALL sample requests only in IDLE; with no request, SHALL stay in IDLE.
REQ-015 SHALL, on any request in IDLE, select owner, latch its address/we/wdata, and enter ISSUE next cycle.
REQ-016 SHALL, in ISSUE (exactly one cycle), assert mem_en and the owner's gnt; mem_we = latched d_we for data owner, 0 for fetch owner.
REQ-017 SHALL hold mem_addr/mem_wdata/mem_we stable from ISSUE until leaving WAIT.
REQ-018 SHALL ignore mem_ready during ISSUE; in WAIT, mem_ready=1 SHALL capture mem_rdata and move to RESP.
REQ-019 SHALL, in RESP (one cycle), pulse owner's valid with captured data on owner's rdata, then return to IDLE.
REQ-020 SHALL hold if_rdata/d_rdata at last captured value between completions; non-owner rdata unchanged.
REQ-021 SHALL give minimum latency: req at cycle N -> gnt N+1 -> mem_ready N+2 -> valid N+3; next grant earliest N+5.
REQ-022 SHALL, without MEM_ARB_RR_EN, use fixed priority: data over fetch when both requested in the same IDLE cycle.
REQ-023 SHALL, on a data write, still pulse d_valid in RESP; d_rdata value then unchanged.
REQ-024 SHALL count WAIT cycles; on reaching TMO without mem_ready, go to RESP, pulse valid, leave rdata unchanged, set err.
REQ-025 SHALL keep err set until reset; err does not block further operation.
REQ-026 SHALL never assert if_gnt and d_gnt, or if_valid and d_valid, in the same cycle.
REQ-027 SHALL not drop an owned transaction if its requester deasserts req after grant.

Reset
REQ-028 SHALL, on rst, go to IDLE asynchronously; all 1-bit outputs 0; mem_addr, mem_wdata, if_rdata, d_rdata all 0.
REQ-029 SHALL, on reset mid-transaction, abandon it without issuing valid; timeout counter 0; round-robin pointer favours data.

Configuration
REQ-030 SHALL support macro MEM_ARB_RR_EN: when defined, on a simultaneous request the requester not granted last wins (pointer updated at each grant); when undefined, REQ-022 fixed priority applies and no pointer exists.

Verification
REQ-031 SHALL test solo fetch: if_req=1, addr 0x0040, mem_ready one cycle after ISSUE, mem_rdata 0x1234 -> if_gnt at N+1, if_valid at N+3, if_rdata=0x1234.
REQ-032 SHALL test data write: d_req=1, d_we=1, addr 0x0100, wdata 0xBEEF -> mem_en=1, mem_we=1, mem_addr=0x0100, mem_wdata=0xBEEF in ISSUE; d_valid pulses; d_rdata unchanged.
REQ-033 SHALL test contention over 3 back-to-back rounds with both reqs held -> without macro, d_gnt every round; with MEM_ARB_RR_EN, d, if, d order.
REQ-034 SHALL test timeout: TMO=16, mem_ready held 0 -> valid exactly 16 cycles after entering WAIT, err=1 and remains 1 through next normal transaction.
REQ-035 SHALL test reset during WAIT -> all outputs 0 immediately, no valid pulse afterwards, next request granted normally.
